temporal_fusion_ctrl: RTL and testbench

- Recursive temporal filter stage wrapped around the LSU frame buffer.
- Accepts the current frame as a beat stream and reads the co-located history beat from the LSU.
- Blends each pixel as new·α + old·(1−α).
- Writes the fused beat back into the LSU and forwards it downstream. It also owns LSU pointer alignment by driving the LSU reset between frames.

---
 rtl/temporal_fusion_ctrl.sv | 158 +++++++++++++++
 tb/tb_temporal_fusion_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_fusion_ctrl.sv
// Recursive temporal filter around the LSU frame buffer: blends each incoming
// beat with its stored history beat, writes the result back and streams it out.
//
// state   | meaning
// S_IDLE  | LSU held in pointer reset, waiting for frame_start
// S_ARM   | one cycle with LSU released so its read pointer lines up with beat 0
// S_RUN   | accepting beats, reading history, pipeline producing fused beats
// S_DRAIN | two cycles to let in-flight fused beats reach the LSU
module temporal_fusion_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int BIT_WIDTH       = 8,
  parameter int ALPHA_BITS      = 8,
  parameter int DATA_WIDTH      = PIXELS_PER_BEAT * BIT_WIDTH,
  parameter int BEATS           = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  frame_start,
  input  logic [ALPHA_BITS:0]   alpha,
  input  logic                  history_clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  lsu_aresetn,
  output logic                  lsu_read_enable,
  input  logic [DATA_WIDTH-1:0] lsu_read_data,
  output logic                  lsu_write_enable,
  output logic [DATA_WIDTH-1:0] lsu_write_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_underrun
);

  localparam int SUM_W = BIT_WIDTH + ALPHA_BITS + 2;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ALPHA_BITS:0] ALPHA_ONE = {1'b1, {ALPHA_BITS{1'b0}}};
  localparam logic [SUM_W-1:0]    ROUND     = SUM_W'(1) << (ALPHA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t                state;
  logic [ALPHA_BITS:0]   alpha_q;
  logic                  hist_valid;
  logic                  clr_pending;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  drain_cnt;
  logic                  s1_valid;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] fused;

  // Invalid history is handled by forcing alpha to one at frame start, so the
  // blend passes the new pixel through and the read data is multiplied by zero.
  for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_pix
    assign fused[i*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(
      (SUM_W'(alpha_q) * SUM_W'(s1_data[i*BIT_WIDTH +: BIT_WIDTH]) +
       SUM_W'(ALPHA_ONE - alpha_q) * SUM_W'(lsu_read_data[i*BIT_WIDTH +: BIT_WIDTH]) +
       ROUND) >> ALPHA_BITS);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state            <= S_IDLE;
      alpha_q          <= ALPHA_ONE;
      hist_valid       <= 1'b0;
      clr_pending      <= 1'b0;
      beat_cnt         <= '0;
      drain_cnt        <= 1'b0;
      s1_valid         <= 1'b0;
      s1_last          <= 1'b0;
      s1_data          <= '0;
      in_ready         <= 1'b0;
      lsu_aresetn      <= 1'b0;
      lsu_read_enable  <= 1'b0;
      lsu_write_enable <= 1'b0;
      lsu_write_data   <= '0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      busy             <= 1'b0;
      err_underrun     <= 1'b0;
    end else begin
      s1_valid         <= 1'b0;
      s1_last          <= 1'b0;
      out_valid        <= s1_valid;
      lsu_write_enable <= s1_valid;
      out_last         <= s1_valid & s1_last;
      if (s1_valid) begin
        out_data       <= fused;
        lsu_write_data <= fused;
      end

      if (history_clear) begin
        hist_valid <= 1'b0;
        if (state != S_IDLE) clr_pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          lsu_aresetn <= 1'b0;
          busy        <= 1'b0;
          if (frame_start) begin
            alpha_q      <= (hist_valid && !history_clear) ?
                            ((alpha > ALPHA_ONE) ? ALPHA_ONE : alpha) : ALPHA_ONE;
            err_underrun <= 1'b0;
            clr_pending  <= 1'b0;
            beat_cnt     <= '0;
            lsu_aresetn  <= 1'b1;
            busy         <= 1'b1;
            state        <= S_ARM;
          end
        end
        S_ARM: begin
          in_ready        <= 1'b1;
          lsu_read_enable <= 1'b1;
          state           <= S_RUN;
        end
        S_RUN: begin
          if (in_valid) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_last  <= (beat_cnt == LAST_BEAT);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              in_ready        <= 1'b0;
              lsu_read_enable <= 1'b0;
              drain_cnt       <= 1'b0;
              state           <= S_DRAIN;
            end
          end else begin
            // Buffer is now misaligned with the frame, so history is unusable.
            err_underrun    <= 1'b1;
            hist_valid      <= 1'b0;
            in_ready        <= 1'b0;
            lsu_read_enable <= 1'b0;
            drain_cnt       <= 1'b0;
            state           <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            lsu_aresetn <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
            if (!err_underrun && !clr_pending && !history_clear) hist_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_fusion_ctrl.sv
// Bench for temporal_fusion_ctrl: behavioural LSU, frame-level reference model
// of the recursive blend, directed plan items plus randomized frames.
module tb_temporal_fusion_ctrl;

  localparam int PPB   = 16;
  localparam int DIM   = 8;
  localparam int BW    = 8;
  localparam int AB    = 8;
  localparam int DW    = PPB * BW;
  localparam int BEATS = DIM * DIM / PPB;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          frame_start = 1'b0;
  logic [AB:0]   alpha = '0;
  logic          history_clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          lsu_aresetn;
  logic          lsu_read_enable;
  logic [DW-1:0] lsu_read_data = '0;
  logic          lsu_write_enable;
  logic [DW-1:0] lsu_write_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          err_underrun;

  temporal_fusion_ctrl #(
    .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .BIT_WIDTH(BW), .ALPHA_BITS(AB)
  ) dut (
    .clk(clk), .areset(areset), .frame_start(frame_start), .alpha(alpha),
    .history_clear(history_clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lsu_aresetn(lsu_aresetn), .lsu_read_enable(lsu_read_enable),
    .lsu_read_data(lsu_read_data), .lsu_write_enable(lsu_write_enable),
    .lsu_write_data(lsu_write_data), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LSU: pointers held at zero in reset, then advance once per enabled access.
  logic [DW-1:0] lsu_mem [BEATS];
  int rd_ptr = 0, wr_ptr = 0;
  always @(posedge clk) begin
    if (!lsu_aresetn) begin
      rd_ptr <= 0;
      wr_ptr <= 0;
    end else begin
      if (lsu_read_enable) begin
        lsu_read_data <= lsu_mem[rd_ptr % BEATS];
        rd_ptr <= rd_ptr + 1;
      end
      if (lsu_write_enable) begin
        lsu_mem[wr_ptr % BEATS] <= lsu_write_data;
        wr_ptr <= wr_ptr + 1;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    logic          we;
    logic          last;
    int            cyc;
  } obs_t;
  obs_t mon_q[$];

  always @(negedge clk) begin
    if (out_valid) mon_q.push_back('{d: out_data, w: lsu_write_data, we: lsu_write_enable,
                                     last: out_last, cyc: cyc});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: last good frame as the buffer should hold it.
  logic [DW-1:0] ref_mem [BEATS];
  bit ref_hv = 1'b0;

  function automatic logic [DW-1:0] ref_blend(input logic [DW-1:0] nw, input logic [DW-1:0] od,
                                              input int a, input bit use_h);
    logic [DW-1:0] r;
    int nv, ov;
    r = '0;
    for (int i = 0; i < PPB; i++) begin
      nv = int'(nw[i*BW +: BW]);
      ov = int'(od[i*BW +: BW]);
      r[i*BW +: BW] = use_h ? BW'((a * nv + ((1 << AB) - a) * ov + (1 << (AB - 1))) / (1 << AB))
                            : BW'(nv);
    end
    return r;
  endfunction

  task automatic clear_hist();
    @(negedge clk);
    history_clear = 1'b1;
    @(negedge clk);
    history_clear = 1'b0;
    ref_hv = 1'b0;
  endtask

  // mode: 0 random pixels, 1 constant cval, 2 pixel i = i, 3 pixel i = 15-i
  task automatic run_frame(input int a, input int gap, input int mode, input int cval,
                           input bit fs_mid);
    logic [DW-1:0] fr [BEATS];
    logic [DW-1:0] exp_b;
    int t_acc [BEATS];
    int acc, t_end, budget, ae, n;
    bit use_h;
    for (int k = 0; k < BEATS; k++) begin
      fr[k] = '0;
      for (int i = 0; i < PPB; i++) begin
        case (mode)
          0:       fr[k][i*BW +: BW] = BW'($urandom_range(0, 255));
          1:       fr[k][i*BW +: BW] = BW'(cval);
          2:       fr[k][i*BW +: BW] = BW'(i);
          default: fr[k][i*BW +: BW] = BW'(15 - i);
        endcase
      end
    end
    use_h = ref_hv;
    ae = (a > (1 << AB)) ? (1 << AB) : a;
    acc = (gap < 0) ? BEATS : gap;
    mon_q.delete();

    @(negedge clk);
    frame_start = 1'b1;
    alpha = (AB+1)'(a);
    @(negedge clk);
    frame_start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_lsu_aresetn", lsu_aresetn, 1);
    chk("arm_in_ready", in_ready, 0);
    @(negedge clk);
    chk("run_in_ready", in_ready, 1);

    for (int k = 0; k < acc; k++) begin
      in_valid = 1'b1;
      in_data = fr[k];
      t_acc[k] = cyc;
      if (fs_mid && k == 1) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    in_valid = 1'b0;
    in_data = '0;
    if (gap >= 0) begin
      t_end = cyc;
      @(negedge clk);
    end else begin
      t_end = t_acc[BEATS-1];
    end
    if (fs_mid) frame_start = 1'b1;
    budget = 0;
    while (busy && budget < 10) begin
      @(negedge clk);
      frame_start = 1'b0;
      budget++;
    end
    frame_start = 1'b0;
    chk("busy_drop_cycle", cyc, t_end + 3);
    @(negedge clk);
    chk("busy_stays_idle", busy, 0);
    chk("idle_lsu_aresetn", lsu_aresetn, 0);
    chk("err_underrun", err_underrun, (gap >= 0) ? 1 : 0);

    n = mon_q.size();
    chk("beats_out", n, acc);
    for (int k = 0; k < acc; k++) begin
      exp_b = ref_blend(fr[k], ref_mem[k], ae, use_h);
      if (k < n) begin
        chk("out_data", mon_q[k].d, exp_b);
        chk("lsu_write_data", mon_q[k].w, exp_b);
        chk("lsu_write_enable", mon_q[k].we, 1);
        chk("out_last", mon_q[k].last, (gap < 0 && k == BEATS-1) ? 1 : 0);
        chk("out_cycle", mon_q[k].cyc, t_acc[k] + 2);
      end
      ref_mem[k] = exp_b;
    end
    ref_hv = (gap < 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < BEATS; k++) begin
      lsu_mem[k] = '0;
      ref_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_lsu_aresetn", lsu_aresetn, 0);
    chk("rst_read_enable", lsu_read_enable, 0);
    chk("rst_write_enable", lsu_write_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_write_data", lsu_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_underrun", err_underrun, 0);
    areset = 1'b0;
    @(negedge clk);

    run_frame(128, -1, 1, 200, 1'b0);   // no history: passes 200 through
    run_frame(128, -1, 1, 100, 1'b0);   // 100 over 200 -> 150
    clear_hist();
    run_frame(77, -1, 1, 0, 1'b0);      // store zeros
    run_frame(64, -1, 1, 255, 1'b0);    // -> 64
    run_frame(256, -1, 0, 0, 1'b0);     // alpha one: new exactly
    run_frame(300, -1, 0, 0, 1'b0);     // clamps to one
    clear_hist();
    run_frame(128, -1, 3, 0, 1'b0);     // history pixel i = 15-i
    run_frame(128, -1, 2, 0, 1'b0);     // -> 8 everywhere
    run_frame(0, -1, 0, 0, 1'b0);       // reads back the 8s

    run_frame(128, 2, 0, 0, 1'b0);      // underrun on beat 2
    run_frame(128, -1, 0, 0, 1'b0);     // history invalid: new passes through

    run_frame(200, -1, 0, 0, 1'b1);     // frame_start during RUN and DRAIN ignored

    // areset in the middle of RUN
    @(negedge clk);
    frame_start = 1'b1;
    alpha = 9'd128;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    areset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_lsu_aresetn", lsu_aresetn, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_write_data", lsu_write_data, 0);
    chk("mid_rst_write_enable", lsu_write_enable, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_read_enable", lsu_read_enable, 0);
    chk("mid_rst_busy", busy, 0);
    areset = 1'b0;
    ref_hv = 1'b0;
    mon_q.delete();
    repeat (4) @(negedge clk);
    chk("no_writes_after_reset", mon_q.size(), 0);
    run_frame(90, -1, 0, 0, 1'b0);

    run_frame(140, -1, 0, 0, 1'b0);     // good frame, then clear in IDLE
    clear_hist();
    run_frame(30, -1, 0, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 4) == 0) clear_hist();
      run_frame(int'($urandom_range(0, 300)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS-1)) : -1,
                0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
